// File: rtl/fp_div_pkg.sv
// Shared types, constants and IEEE-754 operand classification for the
// fp_div_sched divider scheduler.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_INF    = 2'd1,
    CLS_NAN    = 2'd2,
    CLS_FINITE = 2'd3
  } op_class_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] y;
    logic [4:0]  flags;
  } special_t;

  // Subnormals count as finite nonzero operands.
  function automatic op_class_t op_class(input logic [31:0] x);
    op_class_t c;
    if (x[30:23] == EXP_INF) begin
      c = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end else if (x[30:0] == 31'd0) begin
      c = CLS_ZERO;
    end else begin
      c = CLS_FINITE;
    end
    return c;
  endfunction

  // Results for operand pairs that never need the iterative divider.
  function automatic special_t special_div(input logic [31:0] a, input logic [31:0] b);
    op_class_t ca;
    op_class_t cb;
    logic      s;
    special_t  r;
    ca = op_class(a);
    cb = op_class(b);
    s  = a[31] ^ b[31];
    r.hit            = 1'b1;
    r.y              = 32'd0;
    r.flags          = 5'd0;
    r.flags[FLAG_OF] = 1'b0;
    r.flags[FLAG_UF] = 1'b0;
    r.flags[FLAG_NX] = 1'b0;
    if ((ca == CLS_NAN) || (cb == CLS_NAN) ||
        ((ca == CLS_ZERO) && (cb == CLS_ZERO)) ||
        ((ca == CLS_INF) && (cb == CLS_INF))) begin
      r.y              = QNAN;
      r.flags[FLAG_NV] = 1'b1;
    end else if (cb == CLS_ZERO) begin
      r.y              = {s, EXP_INF, 23'd0};
      r.flags[FLAG_DZ] = 1'b1;
    end else if (ca == CLS_INF) begin
      r.y = {s, EXP_INF, 23'd0};
    end else if ((cb == CLS_INF) || (ca == CLS_ZERO)) begin
      r.y = {s, 31'd0};
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_div_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester at or
// after ptr, wrapping modulo NREQ.
module fp_div_rr_arb
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
)
(
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] idx_s;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[idx_s]) begin
        grant_any    = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/fp_div_sched.sv
// Shares one fp_div_rne divider among NREQ requesters. Define
// FP_DIV_SCHED_SPECIAL_EN to resolve IEEE special operands locally.
module fp_div_sched
  import fp_div_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic              div_start,
  output logic [31:0]       div_a,
  output logic [31:0]       div_b,
  input  logic [31:0]       div_y,
  input  logic [4:0]        div_flags,
  input  logic              div_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_y,
  output logic [4:0]        rsp_flags,
  output logic              busy
);

  state_t         state_r;
  logic [IDW-1:0] ptr_r;
  logic [31:0]    a_r;
  logic [31:0]    b_r;
  logic [IDW-1:0] rsp_id_r;
  logic [31:0]    rsp_y_r;
  logic [4:0]     rsp_flags_r;
  logic           rsp_valid_r;
  logic           div_start_r;
  logic           busy_r;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            grant_any_s;
  logic            transfer_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;
  logic [IDW-1:0]  next_ptr_s;

  fp_div_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign transfer_s = (state_r == ST_IDLE) && !rst && grant_any_s;
  assign req_ready  = transfer_s ? grant_s : '0;
  assign sel_a_s    = req_a[32*int'(grant_idx_s) +: 32];
  assign sel_b_s    = req_b[32*int'(grant_idx_s) +: 32];
  assign next_ptr_s = (grant_idx_s == IDW'(NREQ-1)) ? '0 : grant_idx_s + IDW'(1);

`ifdef FP_DIV_SCHED_SPECIAL_EN
  special_t spec_s;
  assign spec_s = special_div(sel_a_s, sel_b_s);
`endif

  // Scheduler FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      rsp_id_r    <= '0;
      rsp_y_r     <= 32'd0;
      rsp_flags_r <= 5'd0;
      rsp_valid_r <= 1'b0;
      div_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (transfer_s) begin
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            rsp_id_r <= grant_idx_s;
            ptr_r    <= next_ptr_s;
            busy_r   <= 1'b1;
`ifdef FP_DIV_SCHED_SPECIAL_EN
            if (spec_s.hit) begin
              state_r     <= ST_RESP;
              rsp_y_r     <= spec_s.y;
              rsp_flags_r <= spec_s.flags;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r     <= ST_ISSUE;
              div_start_r <= 1'b1;
            end
`else
            state_r     <= ST_ISSUE;
            div_start_r <= 1'b1;
`endif
          end
        end
        ST_ISSUE: begin
          div_start_r <= 1'b0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_valid) begin
            rsp_y_r     <= div_y;
            rsp_flags_r <= div_flags;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          div_start_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign div_start = div_start_r;
  assign div_a     = a_r;
  assign div_b     = b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_y     = rsp_y_r;
  assign rsp_flags = rsp_flags_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fp_div_sched.sv
// Self-checking bench for fp_div_sched; the bench plays the divider and
// models arbitration and special-operand results independently.
module tb_fp_div_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_y;
  logic [4:0]  div_flags;
  logic        div_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_y;
  logic [4:0]  rsp_flags;
  logic        busy;

  int tests;
  int fails;
  int m_ptr;

  fp_div_sched #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_y     (div_y),
    .div_flags (div_flags),
    .div_valid (div_valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference round-robin: first valid index at or after the pointer.
  function automatic int model_grant(input logic [1:0] m, input int p);
    for (int k = 0; k < 2; k++) begin
      if (m[(p + k) % 2]) return (p + k) % 2;
    end
    return 0;
  endfunction

  function automatic logic [31:0] rnd_normal();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(1, 254));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_div_start"}, 32'(div_start), 32'd0);
    chk({tag, "_div_a"}, div_a, 32'd0);
    chk({tag, "_div_b"}, div_b, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_y"}, rsp_y, 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic load_ops(input int g, input logic [31:0] a, input logic [31:0] b);
    req_a = {rnd_normal(), rnd_normal()};
    req_b = {rnd_normal(), rnd_normal()};
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
  endtask

  // One operation through the divider, with the response held for 'hold' cycles.
  task automatic run_op(input logic [1:0] mask, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] dy, input logic [4:0] df, input int hold);
    int         g;
    logic [1:0] exp_gnt;
    g = model_grant(mask, m_ptr);
    exp_gnt = 2'b00;
    exp_gnt[g] = 1'b1;
    load_ops(g, a, b);
    req_valid = mask;
    rsp_ready = 1'b0;
    #1;
    chk("grant", 32'(req_ready), 32'(exp_gnt));
    tick();
    m_ptr = (g + 1) % 2;
    chk("start_pulse", 32'(div_start), 32'd1);
    chk("div_a", div_a, a);
    chk("div_b", div_b, b);
    chk("busy_issue", 32'(busy), 32'd1);
    chk("ready_issue", 32'(req_ready), 32'd0);
    tick();
    chk("start_once", 32'(div_start), 32'd0);
    req_a = {rnd_normal(), rnd_normal()};
    req_b = {rnd_normal(), rnd_normal()};
    div_valid = 1'b1;
    div_y = dy;
    div_flags = df;
    tick();
    div_valid = 1'b0;
    div_y = ~dy;
    div_flags = ~df;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_y", rsp_y, dy);
    chk("rsp_flags", 32'(rsp_flags), 32'(df));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("div_a_hold", div_a, a);
    for (int h = 0; h < hold; h++) begin
      div_valid = (h == 0);
      tick();
      div_valid = 1'b0;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_y", rsp_y, dy);
      chk("hold_flags", 32'(rsp_flags), 32'(df));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

`ifdef FP_DIV_SCHED_SPECIAL_EN
  task automatic special_op(input logic [1:0] mask, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ey, input logic [4:0] ef);
    int         g;
    logic [1:0] exp_gnt;
    g = model_grant(mask, m_ptr);
    exp_gnt = 2'b00;
    exp_gnt[g] = 1'b1;
    load_ops(g, a, b);
    req_valid = mask;
    #1;
    chk("sp_grant", 32'(req_ready), 32'(exp_gnt));
    tick();
    req_valid = 2'b00;
    m_ptr = (g + 1) % 2;
    chk("sp_no_start", 32'(div_start), 32'd0);
    chk("sp_valid", 32'(rsp_valid), 32'd1);
    chk("sp_y", rsp_y, ey);
    chk("sp_flags", 32'(rsp_flags), 32'(ef));
    chk("sp_id", 32'(rsp_id), 32'(g));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("sp_done_start", 32'(div_start), 32'd0);
    chk("sp_done_valid", 32'(rsp_valid), 32'd0);
  endtask
`endif

  initial begin
    logic [1:0] mask;
    tests = 0;
    fails = 0;
    m_ptr = 0;
    rst = 1'b1;
    req_valid = 2'b11;
    req_a = 64'd0;
    req_b = 64'd0;
    div_y = 32'd0;
    div_flags = 5'd0;
    div_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    req_valid = 2'b00;
    tick();

    run_op(2'b01, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(2'b11, rnd_normal(), rnd_normal(), $urandom, 5'($urandom), 0);
    end
    run_op(2'b11, rnd_normal(), rnd_normal(), $urandom, 5'($urandom), 5);
    for (int i = 0; i < 6; i++) begin
      mask = 2'($urandom_range(1, 3));
      run_op(mask, rnd_normal(), rnd_normal(), $urandom, 5'($urandom), int'($urandom_range(0, 2)));
    end

`ifdef FP_DIV_SCHED_SPECIAL_EN
    special_op(2'b01, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000);
    special_op(2'b10, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000);
    special_op(2'b11, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 5'b00000);
    special_op(2'b11, 32'h4040_0000, 32'hFF80_0000, 32'h8000_0000, 5'b00000);
    special_op(2'b01, 32'h0000_0000, 32'hC0A0_0000, 32'h8000_0000, 5'b00000);
    special_op(2'b10, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000);
    special_op(2'b11, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000);
`else
    run_op(2'b01, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000, 0);
    run_op(2'b10, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 5'b10101, 0);
`endif

    // Reset while waiting on the divider.
    load_ops(model_grant(2'b01, m_ptr), rnd_normal(), rnd_normal());
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("rw_start", 32'(div_start), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    m_ptr = 0;
    chk_reset_outputs("rst_wait");
    rst = 1'b0;
    div_valid = 1'b1;
    div_y = 32'hDEAD_BEEF;
    div_flags = 5'b11111;
    tick();
    div_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_valid", 32'(rsp_valid), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
      tick();
    end
    run_op(2'b11, rnd_normal(), rnd_normal(), $urandom, 5'($urandom), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
